banco_leitura_idex: RTL and testbench

Read side of the ID-stage register file. Holds the architectural registers, accepts the write-back port, and resolves two source operands per instruction with write-to-read bypass. It captures the operands, their addresses and a valid flag into the ID/EX boundary, with stall and flush control. It sits between instruction decode and the execute stage and is the consumer end of the write-back path.

---
 rtl/banco_leitura_idex_pkg.sv | 29 ++
 rtl/banco_leitura_idex_if.sv | 36 +++
 rtl/banco_leitura_idex_registrador.sv | 19 +
 rtl/banco_leitura_idex.sv | 83 ++++++++
 tb/tb_banco_leitura_idex.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/banco_leitura_idex_pkg.sv
// Shared ID-stage package for the register-file read side.
// Holds the data/address widths, the zero-register index and the
// resolved-read rule used by both read ports and by the stall refresh.
package banco_leitura_idex_pkg;

  localparam int LARGURA  = 32;
  localparam int NUM_REGS = 32;
  localparam int END_BITS = 5;

  localparam logic [END_BITS-1:0] REG_ZERO = '0;

  // Operand seen by a reader of `endereco` this edge: x0 is always zero,
  // a same-edge write to the address wins over the stored value.
  function automatic logic [LARGURA-1:0] resolve_leitura(
    input logic [END_BITS-1:0] endereco,
    input logic                habilita,
    input logic [END_BITS-1:0] end_escrita,
    input logic [LARGURA-1:0]  dado,
    input logic [LARGURA-1:0]  armazenado
  );
    if (endereco == REG_ZERO)
      return '0;
    else if (habilita && (end_escrita == endereco))
      return dado;
    else
      return armazenado;
  endfunction

endpackage

// File: rtl/banco_leitura_idex_if.sv
// Bus between the decode stage and the register-file read side.
// master: decode/write-back side (drives write port, read addresses and
//         stall/flush; observes the ID/EX outputs).
// slave : banco_leitura_idex.
interface banco_leitura_idex_if;
  import banco_leitura_idex_pkg::*;

  logic                habilita_escrita;
  logic [END_BITS-1:0] endereco_escrita;
  logic [LARGURA-1:0]  dado_escrita;
  logic [END_BITS-1:0] endereco_leitura1;
  logic [END_BITS-1:0] endereco_leitura2;
  logic                valido_entrada;
  logic                congela;
  logic                limpa;
  logic [LARGURA-1:0]  dado_leitura1;
  logic [LARGURA-1:0]  dado_leitura2;
  logic [END_BITS-1:0] rs1_saida;
  logic [END_BITS-1:0] rs2_saida;
  logic                valido_saida;

  modport master (
    output habilita_escrita, endereco_escrita, dado_escrita,
           endereco_leitura1, endereco_leitura2, valido_entrada,
           congela, limpa,
    input  dado_leitura1, dado_leitura2, rs1_saida, rs2_saida, valido_saida
  );

  modport slave (
    input  habilita_escrita, endereco_escrita, dado_escrita,
           endereco_leitura1, endereco_leitura2, valido_entrada,
           congela, limpa,
    output dado_leitura1, dado_leitura2, rs1_saida, rs2_saida, valido_saida
  );

endinterface

// File: rtl/banco_leitura_idex_registrador.sv
// registrador: one architectural register of the ID stage.
// Ports: clk (state on negedge), reset (sync, active-high, wins over
// the write), habilita (write enable), d (write data), q (stored value).
module registrador #(
  parameter int LARGURA = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               habilita,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  always_ff @(negedge clk) begin
    if (reset)         q <= '0;
    else if (habilita) q <= d;
  end

endmodule

// File: rtl/banco_leitura_idex.sv
// banco_leitura_idex: register file read side plus the ID/EX latch.
// Ports:
//   clk   - clock; every state change happens on the negative edge
//   reset - synchronous, active-high, sampled on the negative edge
//   bus   - slave side of banco_leitura_idex_if: write-back port,
//           two read addresses, valido_entrada, congela/limpa, and the
//           registered ID/EX outputs (operands, addresses, valid).
// Operands are resolved with write-to-read bypass, so a write-back on
// the same edge is seen by the instruction being captured.
module banco_leitura_idex
  import banco_leitura_idex_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  banco_leitura_idex_if.slave   bus
);

  logic [NUM_REGS-1:0][LARGURA-1:0] arquivo;
  logic [LARGURA-1:0]  leitura1, leitura2;

  logic [LARGURA-1:0]  dado1_q, dado2_q;
  logic [END_BITS-1:0] rs1_q, rs2_q;
  logic                valido_q;

  // x0 has no storage; it reads as zero and writes to it go nowhere.
  assign arquivo[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    registrador #(.LARGURA(LARGURA)) u_reg (
      .clk      (clk),
      .reset    (reset),
      .habilita (bus.habilita_escrita && (bus.endereco_escrita == END_BITS'(i))),
      .d        (bus.dado_escrita),
      .q        (arquivo[i])
    );
  end

  always_comb begin
    leitura1 = resolve_leitura(bus.endereco_leitura1, bus.habilita_escrita,
                               bus.endereco_escrita, bus.dado_escrita,
                               arquivo[bus.endereco_leitura1]);
    leitura2 = resolve_leitura(bus.endereco_leitura2, bus.habilita_escrita,
                               bus.endereco_escrita, bus.dado_escrita,
                               arquivo[bus.endereco_leitura2]);
  end

  // ID/EX latch. Under stall the held operand is re-resolved against its
  // own held address with the held value as "stored": a matching write
  // refreshes it, anything else keeps it (x0 stays zero).
  always_ff @(negedge clk) begin
    if (reset) begin
      dado1_q  <= '0;
      dado2_q  <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      valido_q <= 1'b0;
    end else if (bus.limpa) begin
      dado1_q  <= '0;
      dado2_q  <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      valido_q <= 1'b0;
    end else if (bus.congela) begin
      dado1_q  <= resolve_leitura(rs1_q, bus.habilita_escrita,
                                  bus.endereco_escrita, bus.dado_escrita, dado1_q);
      dado2_q  <= resolve_leitura(rs2_q, bus.habilita_escrita,
                                  bus.endereco_escrita, bus.dado_escrita, dado2_q);
    end else begin
      dado1_q  <= leitura1;
      dado2_q  <= leitura2;
      rs1_q    <= bus.endereco_leitura1;
      rs2_q    <= bus.endereco_leitura2;
      valido_q <= bus.valido_entrada;
    end
  end

  assign bus.dado_leitura1 = dado1_q;
  assign bus.dado_leitura2 = dado2_q;
  assign bus.rs1_saida     = rs1_q;
  assign bus.rs2_saida     = rs2_q;
  assign bus.valido_saida  = valido_q;

endmodule

// File: tb/tb_banco_leitura_idex.sv
// Scoreboard bench: the driver applies inputs after each posedge, runs a
// behavioural model of the register file and ID/EX slot, and queues the
// outputs expected after the following negedge; the monitor pops and
// compares shortly after every negedge.
module tb_banco_leitura_idex;
  import banco_leitura_idex_pkg::*;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  banco_leitura_idex_if bus ();

  banco_leitura_idex dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [32];
  exp_t        model;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nome, act, req, $time);
    end
  endtask

  // One clock: apply inputs, advance the model to what the next negedge
  // must produce, and queue that as the expected response.
  task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                      input logic v, input logic c, input logic l);
    logic [31:0] r1, r2;
    @(posedge clk);
    #1;
    reset                 = rst;
    bus.habilita_escrita  = we;
    bus.endereco_escrita  = wa;
    bus.dado_escrita      = wd;
    bus.endereco_leitura1 = a1;
    bus.endereco_leitura2 = a2;
    bus.valido_entrada    = v;
    bus.congela           = c;
    bus.limpa             = l;
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      model = '{default: '0};
    end else begin
      r1 = (a1 == 0) ? 32'h0 : ((we && wa == a1) ? wd : mem[a1]);
      r2 = (a2 == 0) ? 32'h0 : ((we && wa == a2) ? wd : mem[a2]);
      if (l) begin
        model = '{default: '0};
      end else if (c) begin
        if (we && wa != 0 && wa == model.r1) model.d1 = wd;
        if (we && wa != 0 && wa == model.r2) model.d2 = wd;
      end else begin
        model.d1 = r1; model.d2 = r2;
        model.r1 = a1; model.r2 = a2;
        model.v  = v;
      end
      if (we && wa != 0) mem[wa] = wd;
    end
    sb_q.push_back(model);
  endtask

  // Monitor: one expected entry per negedge once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("dado_leitura1", bus.dado_leitura1, e.d1);
        chk("dado_leitura2", bus.dado_leitura2, e.d2);
        chk("rs1_saida",     32'(bus.rs1_saida), 32'(e.r1));
        chk("rs2_saida",     32'(bus.rs2_saida), 32'(e.r2));
        chk("valido_saida",  32'(bus.valido_saida), 32'(e.v));
      end
    end
  end

  initial begin
    logic [4:0] wa, a1, a2;
    logic       rst, we, v, c, l;
    reset = 1'b1;
    bus.habilita_escrita = 0; bus.endereco_escrita = 0; bus.dado_escrita = 0;
    bus.endereco_leitura1 = 0; bus.endereco_leitura2 = 0;
    bus.valido_entrada = 0; bus.congela = 0; bus.limpa = 0;
    model = '{default: '0};
    for (int i = 0; i < 32; i++) mem[i] = '0;

    //   rst we wa  wd            a1  a2  v  c  l
    step(1, 0, 0,  32'h0,        0,  0,  0, 0, 0);
    step(1, 1, 5,  32'h11111111, 5,  5,  1, 1, 1);
    // reset wipes a stored value
    step(0, 1, 5,  32'hDEADBEEF, 0,  0,  1, 0, 0);
    step(1, 0, 0,  32'h0,        5,  5,  1, 0, 0);
    step(0, 0, 0,  32'h0,        5,  5,  1, 0, 0);
    // write then read next edge
    step(0, 1, 7,  32'h12345678, 0,  0,  0, 0, 0);
    step(0, 0, 0,  32'h0,        7,  0,  1, 0, 0);
    step(0, 0, 0,  32'h0,        7,  0,  0, 0, 0);
    // bypass, and x0 discards writes
    step(0, 1, 3,  32'hA5A5A5A5, 3,  3,  1, 0, 0);
    step(0, 1, 0,  32'hFFFFFFFF, 0,  3,  1, 0, 0);
    // stall refresh
    step(0, 1, 9,  32'h00000001, 0,  0,  1, 0, 0);
    step(0, 0, 0,  32'h0,        9,  7,  1, 0, 0);
    step(0, 1, 9,  32'h00000042, 1,  2,  0, 1, 0);
    step(0, 1, 10, 32'h0BADF00D, 10, 10, 0, 1, 0);
    step(0, 0, 0,  32'h0,        10, 9,  1, 0, 0);
    // flush beats stall; write still lands
    step(0, 1, 4,  32'h00000077, 4,  4,  1, 1, 1);
    step(0, 0, 0,  32'h0,        4,  3,  1, 0, 0);

    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      we  = ($urandom_range(0, 3) != 0);
      wa  = 5'($urandom_range(0, 7));
      a1  = 5'($urandom_range(0, 7));
      a2  = ($urandom_range(0, 4) == 0) ? a1 : 5'($urandom_range(0, 31));
      v   = 1'($urandom_range(0, 1));
      c   = ($urandom_range(0, 3) == 0);
      l   = ($urandom_range(0, 7) == 0);
      step(rst, we, wa, $urandom, a1, a2, v, c, l);
    end

    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
